// File: rtl/direction_queue.sv
// Direction input stage: synchronises and edge-detects the pushbuttons, filters illegal
// turns, buffers pending turns and emits one direction update per move tick.
module direction_queue #(
    parameter int DEPTH       = 2,
    parameter int MOVE_PERIOD = 1500000,
    parameter int CNT_W       = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_reset,
    input  logic [3:0] pb_dir,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic       running,
    output logic [2:0] q_count,
    output logic       dropped
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t           r_state;
    logic [3:0]       r_sync1, r_sync2, r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_fifo [0:3];
    logic [1:0]       r_head, r_tail;

    logic [3:0] w_edge;
    logic       w_press;
    logic [1:0] w_press_dir;
    logic [1:0] w_tail_last;
    logic [1:0] w_ref;
    logic       w_legal, w_active, w_tick, w_pop, w_push, w_drop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= pb_dir;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge  = r_sync2 & ~r_prev;
    assign w_press = |w_edge;

    // Button to direction code, up > down > left > right when edges coincide.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        w_press_dir = 2'd0;
        if (w_edge[3])      w_press_dir = 2'd2;
        else if (w_edge[2]) w_press_dir = 2'd3;
        else if (w_edge[1]) w_press_dir = 2'd1;
    end

    assign w_tail_last = (r_tail == 2'd0) ? 2'(DEPTH - 1) : r_tail - 2'd1;
    assign w_ref       = (q_count != 3'd0) ? r_fifo[w_tail_last] : dir;
    assign w_legal     = w_press && (w_press_dir != w_ref)
                                 && (w_press_dir != {w_ref[1], ~w_ref[0]});
    assign w_active    = (r_state == RUN) && !game_over;
    assign w_tick      = w_active && (r_cnt == CNT_W'(MOVE_PERIOD - 1));
    assign w_pop       = w_tick && (q_count != 3'd0);
    assign w_push      = w_active && w_legal && ((q_count < 3'(DEPTH)) || w_pop);
    assign w_drop      = w_active && w_legal && !w_push;

    // NOTE: queue storage carries no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_tail] <= w_press_dir;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            dir       <= 2'd0;
            move_tick <= 1'b0;
            running   <= 1'b0;
            q_count   <= 3'd0;
            dropped   <= 1'b0;
        end else if (s_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            dir       <= 2'd0;
            move_tick <= 1'b0;
            running   <= 1'b0;
            q_count   <= 3'd0;
            dropped   <= 1'b0;
        end else begin
            move_tick <= 1'b0;
            dropped   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        dir     <= w_press_dir;
                        r_state <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (game_over) begin
                        r_state <= HALT;
                        running <= 1'b0;
                    end else begin
                        r_cnt     <= w_tick ? '0 : r_cnt + CNT_W'(1);
                        move_tick <= w_tick;
                        dropped   <= w_drop;
                        if (w_pop) begin
                            dir    <= r_fifo[r_head];
                            r_head <= ptr_next(r_head);
                        end
                        if (w_push) r_tail <= ptr_next(r_tail);
                        case ({w_push, w_pop})
                            2'b10:   q_count <= q_count + 3'd1;
                            2'b01:   q_count <= q_count - 3'd1;
                            default: q_count <= q_count;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
